// File: rtl/pwm_throttle_sequencer_if.sv
// Command handshake between the CPU PIO registers and the throttle sequencer.
interface pwm_throttle_sequencer_if #(parameter int W = 28);
  logic [W-1:0] cmd_period;
  logic [W-1:0] cmd_duty;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_err;

  modport master (output cmd_period, cmd_duty, cmd_valid, input cmd_ready, cmd_err);
  modport slave  (input cmd_period, cmd_duty, cmd_valid, output cmd_ready, cmd_err);
endinterface

// File: rtl/pwm_throttle_sequencer.sv
// Period/duty sequencer for one ESC channel: arming, slew-limited run, controlled stop.
// Optional command watchdog enabled by defining PWM_THROTTLE_WDOG_EN.
module pwm_throttle_sequencer #(
`ifdef PWM_THROTTLE_WDOG_EN
  parameter int WDOG_PERIODS = 25,
`endif
  parameter int W           = 28,
  parameter int DEF_PERIOD  = 1000000,
  parameter int MIN_PERIOD  = 1000,
  parameter int ARM_DUTY    = 50000,
  parameter int ARM_PERIODS = 100,
  parameter int SLEW_STEP   = 500,
  parameter int STOP_STEP   = 2000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pwm_throttle_sequencer_if.slave       cmd,
  input  logic                          arm_req,
  input  logic                          stop_req,
  input  logic                          period_end,
  output logic [W-1:0]                  pwm_period,
  output logic [W-1:0]                  pwm_duty,
  output logic [1:0]                    state,
  output logic                          clip,
  output logic                          wdog_trip
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMING   = 2'b01,
    RUN      = 2'b10,
    STOP     = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(ARM_PERIODS + 1);
  localparam logic [W-1:0] DEF_PERIOD_W = W'(DEF_PERIOD);
  localparam logic [W-1:0] MIN_PERIOD_W = W'(MIN_PERIOD);
  localparam logic [W-1:0] ARM_DUTY_W   = W'(ARM_DUTY);
  localparam logic [W-1:0] SLEW_STEP_W  = W'(SLEW_STEP);
  localparam logic [W-1:0] STOP_STEP_W  = W'(STOP_STEP);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_PERIODS - 1);

  state_t           cur;
  logic [W-1:0]     next_period;
  logic [W-1:0]     target;
  logic [CNT_W-1:0] arm_cnt;
  logic             cmd_seen;
  logic             err_q;
  logic             accept;
  logic [W-1:0]     clamp_lo;
  logic [W-1:0]     clamped;
  logic [W-1:0]     slew_duty;
  logic [W-1:0]     run_duty;

  assign cmd.cmd_ready = (cur == ARMING) || (cur == RUN);
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign state         = cur;

  // Command duty is lifted to the arming floor first, then capped by its own period.
  always_comb begin
    clamp_lo = (cmd.cmd_duty < ARM_DUTY_W) ? ARM_DUTY_W : cmd.cmd_duty;
    clamped  = (clamp_lo > cmd.cmd_period) ? cmd.cmd_period : clamp_lo;
  end

  // Step toward target without overshoot, then cap by the period about to be loaded.
  always_comb begin
    slew_duty = target;
    if (target > pwm_duty) begin
      if ((target - pwm_duty) > SLEW_STEP_W) slew_duty = pwm_duty + SLEW_STEP_W;
    end else if (pwm_duty - target > SLEW_STEP_W) begin
      slew_duty = pwm_duty - SLEW_STEP_W;
    end
    run_duty = (slew_duty > next_period) ? next_period : slew_duty;
  end

`ifdef PWM_THROTTLE_WDOG_EN
  localparam int WD_W = $clog2(WDOG_PERIODS + 1);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_PERIODS - 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            trip_q;
  assign wdog_trip = trip_q;
`else
  assign wdog_trip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= DISARMED;
      pwm_period  <= DEF_PERIOD_W;
      pwm_duty    <= '0;
      next_period <= DEF_PERIOD_W;
      target      <= '0;
      arm_cnt     <= '0;
      cmd_seen    <= 1'b0;
      clip        <= 1'b0;
      err_q       <= 1'b0;
`ifdef PWM_THROTTLE_WDOG_EN
      wdog_cnt    <= '0;
      trip_q      <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (cur)
        DISARMED: begin
          pwm_duty <= '0;
          if (arm_req && !stop_req) begin
            cur      <= ARMING;
            clip     <= 1'b0;
            arm_cnt  <= '0;
            cmd_seen <= 1'b0;
`ifdef PWM_THROTTLE_WDOG_EN
            trip_q   <= 1'b0;
`endif
          end
        end
        ARMING: begin
          if (stop_req || !arm_req) begin
            cur <= STOP;
          end else if (period_end) begin
            pwm_duty   <= ARM_DUTY_W;
            pwm_period <= next_period;
            if (arm_cnt == ARM_LAST) begin
              cur <= RUN;
              if (!cmd_seen) target <= ARM_DUTY_W;
`ifdef PWM_THROTTLE_WDOG_EN
              wdog_cnt <= '0;
`endif
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (stop_req || !arm_req) begin
            cur <= STOP;
          end else if (period_end) begin
            pwm_period <= next_period;
            pwm_duty   <= run_duty;
`ifdef PWM_THROTTLE_WDOG_EN
            if (wdog_cnt == WDOG_LAST) begin
              cur    <= STOP;
              trip_q <= 1'b1;
            end else begin
              wdog_cnt <= wdog_cnt + 1'b1;
            end
`endif
          end
        end
        STOP: begin
          if (period_end) begin
            if (pwm_duty == '0) cur <= DISARMED;
            else pwm_duty <= (pwm_duty > STOP_STEP_W) ? pwm_duty - STOP_STEP_W : '0;
          end
        end
        default: cur <= DISARMED;
      endcase

      // Written after the FSM so a command accepted on the last arming period keeps its target.
      if (accept) begin
`ifdef PWM_THROTTLE_WDOG_EN
        wdog_cnt <= '0;
`endif
        if (cmd.cmd_period < MIN_PERIOD_W) begin
          err_q <= 1'b1;
        end else begin
          next_period <= cmd.cmd_period;
          target      <= clamped;
          if (clamped != cmd.cmd_duty) clip <= 1'b1;
          if (cur == ARMING) cmd_seen <= 1'b1;
        end
      end
    end
  end

endmodule
